// File: rtl/pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain
//
// Parameterisable chain of valid/ready pipeline stages sitting between an
// upstream (s_*) and a downstream (m_*) channel.
//
//   REG_TYPE 0 : bypass wire, no state, occupancy always 0, flush ignored
//   REG_TYPE 1 : forward register per stage, ready passes back combinationally
//   REG_TYPE 2 : skid buffer per stage (main + skid register), every stage
//                ready comes straight from a flop
//
// Ports
//   clk        : sole clock, all state on the rising edge
//   rst        : asynchronous active-high reset
//   flush      : synchronous discard of every held word
//   s_data     : upstream payload            (DATA_WIDTH)
//   s_valid    : upstream word valid
//   s_ready    : this block can take a word
//   m_data     : downstream payload          (DATA_WIDTH)
//   m_valid    : downstream word valid
//   m_ready    : downstream can take a word
//   occupancy  : number of words currently held (OCC_WIDTH)
//
// Data registers carry no reset; only valid bits, stage states, ready flops
// and the occupancy counter are reset.
// -----------------------------------------------------------------------------
module pipe_reg_chain #(
  parameter int DATA_WIDTH = 128,
  parameter int REG_TYPE   = 2,
  parameter int REG_LENGTH = 1,
  localparam int OCC_WIDTH = $clog2(2*REG_LENGTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OCC_WIDTH-1:0]  occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  logic                 acc_s;
  logic                 del_s;
  logic [OCC_WIDTH-1:0] occ_q;
  logic [OCC_WIDTH-1:0] occ_d;

  assign acc_s = s_valid & s_ready;
  assign del_s = m_valid & m_ready;

  // Occupancy next state: held + accepted - delivered, cleared by flush.
  always_comb begin
    occ_d = occ_q;
    if (REG_TYPE == 0) begin
      occ_d = {OCC_WIDTH{1'b0}};
    end else if (flush) begin
      occ_d = {OCC_WIDTH{1'b0}};
    end else begin
      occ_d = occ_q + OCC_WIDTH'(acc_s) - OCC_WIDTH'(del_s);
    end
  end

  // Occupancy counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= {OCC_WIDTH{1'b0}};
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

  if (REG_TYPE == 1) begin : g_fwd
    // ---------------------------------------------------------------------
    // Forward-register chain: one data register plus valid bit per stage.
    // ---------------------------------------------------------------------
    logic                  en_q;
    logic [REG_LENGTH-1:0] vld_q;
    logic [REG_LENGTH-1:0] vld_d;
    logic [REG_LENGTH-1:0] in_vld_s;
    logic [REG_LENGTH-1:0] rdy_s;
    logic [DATA_WIDTH-1:0] dat_q    [REG_LENGTH];
    logic [DATA_WIDTH-1:0] dat_d    [REG_LENGTH];
    logic [DATA_WIDTH-1:0] in_dat_s [REG_LENGTH];

    // en_q keeps the input closed during reset and opens it on the first
    // edge after release; flush closes it for the flush cycle only.
    assign in_vld_s[0] = s_valid & en_q & ~flush;
    assign in_dat_s[0] = s_data;

    for (genvar i = 1; i < REG_LENGTH; i++) begin : g_link
      assign in_vld_s[i] = vld_q[i-1];
      assign in_dat_s[i] = dat_q[i-1];
    end

    // A stage can load when downstream takes a word this cycle or when any
    // stage from here to the output is empty (the bubble collapses).
    for (genvar i = 0; i < REG_LENGTH; i++) begin : g_rdy
      assign rdy_s[i] = m_ready | ~(&vld_q[REG_LENGTH-1:i]);
    end

    // Stage next state: load from upstream when ready, otherwise hold.
    always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      for (int i = 0; i < REG_LENGTH; i++) begin
        if (flush) begin
          vld_d[i] = 1'b0;
        end else if (rdy_s[i]) begin
          vld_d[i] = in_vld_s[i];
          if (in_vld_s[i]) begin
            dat_d[i] = in_dat_s[i];
          end else begin
            dat_d[i] = dat_q[i];
          end
        end else begin
          vld_d[i] = vld_q[i];
        end
      end
    end

    // Valid bits and input enable.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        en_q  <= 1'b0;
        vld_q <= {REG_LENGTH{1'b0}};
      end else begin
        en_q  <= 1'b1;
        vld_q <= vld_d;
      end
    end

    // Payload registers, intentionally without reset.
    always_ff @(posedge clk) begin
      dat_q <= dat_d;
    end

    assign s_ready = rdy_s[0] & en_q & ~flush;
    assign m_valid = vld_q[REG_LENGTH-1];
    assign m_data  = dat_q[REG_LENGTH-1];

  end else if (REG_TYPE == 2) begin : g_skid
    // ---------------------------------------------------------------------
    // Skid-buffer chain: main + skid register per stage, ready from a flop.
    // ---------------------------------------------------------------------
    skid_state_e           state_q [REG_LENGTH];
    skid_state_e           state_d [REG_LENGTH];
    logic [REG_LENGTH-1:0] rdy_q;
    logic [REG_LENGTH-1:0] rdy_d;
    logic [REG_LENGTH-1:0] in_vld_s;
    logic [REG_LENGTH-1:0] out_vld_s;
    logic [REG_LENGTH-1:0] out_rdy_s;
    logic [REG_LENGTH-1:0] stg_acc_s;
    logic [REG_LENGTH-1:0] stg_drn_s;
    logic [DATA_WIDTH-1:0] main_q   [REG_LENGTH];
    logic [DATA_WIDTH-1:0] main_d   [REG_LENGTH];
    logic [DATA_WIDTH-1:0] skid_q   [REG_LENGTH];
    logic [DATA_WIDTH-1:0] skid_d   [REG_LENGTH];
    logic [DATA_WIDTH-1:0] in_dat_s [REG_LENGTH];

    // rdy_q[0] is 0 throughout reset, so no extra enable is needed here.
    assign in_vld_s[0]            = s_valid & ~flush;
    assign in_dat_s[0]            = s_data;
    assign out_rdy_s[REG_LENGTH-1] = m_ready;

    for (genvar i = 0; i < REG_LENGTH; i++) begin : g_out
      assign out_vld_s[i] = (state_q[i] != ST_EMPTY);
    end

    for (genvar i = 1; i < REG_LENGTH; i++) begin : g_link
      assign in_vld_s[i]    = out_vld_s[i-1];
      assign in_dat_s[i]    = main_q[i-1];
      assign out_rdy_s[i-1] = rdy_q[i];
    end

    assign stg_acc_s = in_vld_s & rdy_q;
    assign stg_drn_s = out_vld_s & out_rdy_s;

    // Per-stage EMPTY/ONE/FULL transitions; ready for the next cycle is
    // precomputed from the next state so it can be a plain flop.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      rdy_d   = rdy_q;
      for (int i = 0; i < REG_LENGTH; i++) begin
        if (flush) begin
          state_d[i] = ST_EMPTY;
        end else begin
          case (state_q[i])
            ST_EMPTY: begin
              if (stg_acc_s[i]) begin
                state_d[i] = ST_ONE;
                main_d[i]  = in_dat_s[i];
              end else begin
                state_d[i] = ST_EMPTY;
              end
            end
            ST_ONE: begin
              if (stg_acc_s[i] && stg_drn_s[i]) begin
                state_d[i] = ST_ONE;
                main_d[i]  = in_dat_s[i];
              end else if (stg_acc_s[i]) begin
                // Output stalled: park the new word in the skid register so
                // the main register (m_data) stays stable.
                state_d[i] = ST_FULL;
                skid_d[i]  = in_dat_s[i];
              end else if (stg_drn_s[i]) begin
                state_d[i] = ST_EMPTY;
              end else begin
                state_d[i] = ST_ONE;
              end
            end
            ST_FULL: begin
              if (stg_drn_s[i]) begin
                state_d[i] = ST_ONE;
                main_d[i]  = skid_q[i];
              end else begin
                state_d[i] = ST_FULL;
              end
            end
            default: begin
              state_d[i] = ST_EMPTY;
            end
          endcase
        end
        rdy_d[i] = (state_d[i] != ST_FULL);
      end
    end

    // Stage state and ready flops.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < REG_LENGTH; i++) begin
          state_q[i] <= ST_EMPTY;
        end
        rdy_q <= {REG_LENGTH{1'b0}};
      end else begin
        state_q <= state_d;
        rdy_q   <= rdy_d;
      end
    end

    // Main and skid payload registers, intentionally without reset.
    always_ff @(posedge clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
    end

    assign s_ready = rdy_q[0] & ~flush;
    assign m_valid = out_vld_s[REG_LENGTH-1];
    assign m_data  = main_q[REG_LENGTH-1];

  end else begin : g_bypass
    // ---------------------------------------------------------------------
    // Bypass: pure wires in both directions.
    // ---------------------------------------------------------------------
    assign m_data  = s_data;
    assign m_valid = s_valid;
    assign s_ready = m_ready;
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg_chain
//
// Five pipe_reg_chain instances share one set of upstream/downstream inputs;
// each directed phase checks the instance it targets:
//   a : type 2, length 2   stream of 0..99
//   b : type 2, length 1   backpressure
//   c : type 1, length 3   flush
//   d : type 2, length 4   reset mid-stream
//   e : type 0             bypass
// A final randomised phase scoreboards c and d and checks e every cycle.
// -----------------------------------------------------------------------------
module tb_pipe_reg_chain;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] s_data;
  logic        s_valid;
  logic        m_ready;

  logic        a_s_ready, a_m_valid;
  logic [15:0] a_m_data;
  logic [2:0]  a_occ;
  logic        b_s_ready, b_m_valid;
  logic [15:0] b_m_data;
  logic [1:0]  b_occ;
  logic        c_s_ready, c_m_valid;
  logic [15:0] c_m_data;
  logic [2:0]  c_occ;
  logic        d_s_ready, d_m_valid;
  logic [15:0] d_m_data;
  logic [3:0]  d_occ;
  logic        e_s_ready, e_m_valid;
  logic [15:0] e_m_data;
  logic [1:0]  e_occ;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  pipe_reg_chain #(.DATA_WIDTH(16), .REG_TYPE(2), .REG_LENGTH(2)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(a_s_ready),
    .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(m_ready),
    .occupancy(a_occ));

  pipe_reg_chain #(.DATA_WIDTH(16), .REG_TYPE(2), .REG_LENGTH(1)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(b_s_ready),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(m_ready),
    .occupancy(b_occ));

  pipe_reg_chain #(.DATA_WIDTH(16), .REG_TYPE(1), .REG_LENGTH(3)) u_c (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(c_s_ready),
    .m_data(c_m_data), .m_valid(c_m_valid), .m_ready(m_ready),
    .occupancy(c_occ));

  pipe_reg_chain #(.DATA_WIDTH(16), .REG_TYPE(2), .REG_LENGTH(4)) u_d (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(d_s_ready),
    .m_data(d_m_data), .m_valid(d_m_valid), .m_ready(m_ready),
    .occupancy(d_occ));

  pipe_reg_chain #(.DATA_WIDTH(16), .REG_TYPE(0), .REG_LENGTH(1)) u_e (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(e_s_ready),
    .m_data(e_m_data), .m_valid(e_m_valid), .m_ready(m_ready),
    .occupancy(e_occ));

  // One comparison: count it, and on mismatch count and report it.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse, then one edge so the registered types reopen s_ready.
  task automatic reset_seq();
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  logic [15:0] qc[$];
  logic [15:0] qd[$];
  logic        c_stall, d_stall;
  logic [15:0] c_hold, d_hold;
  int          n;

  initial begin
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 16'h0000;

    // ---------------- reset state ----------------
    cyc(); cyc();
    #1;
    chk("rst_a_mvalid", 32'(a_m_valid), 32'd0);
    chk("rst_a_occ",    32'(a_occ),     32'd0);
    chk("rst_a_sready", 32'(a_s_ready), 32'd0);
    chk("rst_c_sready", 32'(c_s_ready), 32'd0);
    chk("rst_d_sready", 32'(d_s_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_b_sready_pre", 32'(b_s_ready), 32'd0);
    chk("rel_c_sready_pre", 32'(c_s_ready), 32'd0);
    cyc();
    #1;
    chk("rel_b_sready_post", 32'(b_s_ready), 32'd1);
    chk("rel_c_sready_post", 32'(c_s_ready), 32'd1);

    // ---------------- stream on a (type 2, length 2) ----------------
    for (int j = 0; j < 102; j++) begin
      cyc();
      m_ready = 1'b1;
      s_valid = (j < 100);
      s_data  = 16'(j);
      #1;
      if (j < 100) chk("stream_sready", 32'(a_s_ready), 32'd1);
      if (j < 2) begin
        chk("stream_lat_mvalid", 32'(a_m_valid), 32'd0);
      end else begin
        chk("stream_mvalid", 32'(a_m_valid), 32'd1);
        chk("stream_mdata",  32'(a_m_data),  32'(j - 2));
      end
    end
    reset_seq();

    // ---------------- backpressure on b (type 2, length 1) ----------------
    cyc(); m_ready = 1'b0; s_valid = 1'b1; s_data = 16'h00A1; #1;
    chk("bp_sready0", 32'(b_s_ready), 32'd1);
    chk("bp_occ0",    32'(b_occ),     32'd0);
    cyc(); s_data = 16'h00B2; #1;
    chk("bp_sready1", 32'(b_s_ready), 32'd1);
    chk("bp_mvalid1", 32'(b_m_valid), 32'd1);
    chk("bp_mdata1",  32'(b_m_data),  32'h00A1);
    chk("bp_occ1",    32'(b_occ),     32'd1);
    cyc(); s_data = 16'h00C3; #1;
    chk("bp_sready2", 32'(b_s_ready), 32'd0);
    chk("bp_occ2",    32'(b_occ),     32'd2);
    chk("bp_mdata2",  32'(b_m_data),  32'h00A1);
    cyc(); s_valid = 1'b0; m_ready = 1'b1; #1;
    chk("bp_occ3",    32'(b_occ),     32'd2);
    chk("bp_mdata3",  32'(b_m_data),  32'h00A1);
    cyc(); #1;
    chk("bp_mvalid4", 32'(b_m_valid), 32'd1);
    chk("bp_mdata4",  32'(b_m_data),  32'h00B2);
    chk("bp_occ4",    32'(b_occ),     32'd1);
    cyc(); #1;
    chk("bp_mvalid5", 32'(b_m_valid), 32'd0);
    chk("bp_occ5",    32'(b_occ),     32'd0);
    reset_seq();

    // ---------------- flush on c (type 1, length 3) ----------------
    cyc(); m_ready = 1'b0; s_valid = 1'b1; s_data = 16'h0011; #1;
    chk("fl_sready0", 32'(c_s_ready), 32'd1);
    cyc(); s_data = 16'h0022; #1;
    chk("fl_sready1", 32'(c_s_ready), 32'd1);
    cyc(); s_data = 16'h0033; #1;
    chk("fl_sready2", 32'(c_s_ready), 32'd1);
    cyc(); s_valid = 1'b0; #1;
    chk("fl_occ3",    32'(c_occ),     32'd3);
    chk("fl_mvalid3", 32'(c_m_valid), 32'd1);
    chk("fl_mdata3",  32'(c_m_data),  32'h0011);
    cyc(); flush = 1'b1; s_valid = 1'b1; s_data = 16'h0044; m_ready = 1'b1; #1;
    chk("fl_sready_flush", 32'(c_s_ready), 32'd0);
    chk("fl_mvalid_flush", 32'(c_m_valid), 32'd1);
    chk("fl_mdata_flush",  32'(c_m_data),  32'h0011);
    cyc(); flush = 1'b0; s_data = 16'h0055; #1;
    chk("fl_mvalid5", 32'(c_m_valid), 32'd0);
    chk("fl_occ5",    32'(c_occ),     32'd0);
    chk("fl_sready5", 32'(c_s_ready), 32'd1);
    cyc(); s_data = 16'h0066; #1;
    chk("fl_mvalid6", 32'(c_m_valid), 32'd0);
    cyc(); s_valid = 1'b0; #1;
    chk("fl_mvalid7", 32'(c_m_valid), 32'd0);
    cyc(); #1;
    chk("fl_mvalid8", 32'(c_m_valid), 32'd1);
    chk("fl_mdata8",  32'(c_m_data),  32'h0055);
    cyc(); #1;
    chk("fl_mvalid9", 32'(c_m_valid), 32'd1);
    chk("fl_mdata9",  32'(c_m_data),  32'h0066);
    cyc(); #1;
    chk("fl_mvalid10", 32'(c_m_valid), 32'd0);
    chk("fl_occ10",    32'(c_occ),     32'd0);
    reset_seq();

    // ---------------- reset mid-stream on d (type 2, length 4) ----------------
    for (int k = 0; k < 5; k++) begin
      cyc(); m_ready = 1'b0; s_valid = 1'b1; s_data = 16'(16'h0100 + k); #1;
      chk("mr_sready", 32'(d_s_ready), 32'd1);
    end
    cyc(); s_valid = 1'b0; #1;
    chk("mr_occ5",    32'(d_occ),     32'd5);
    chk("mr_mvalid5", 32'(d_m_valid), 32'd1);
    chk("mr_mdata5",  32'(d_m_data),  32'h0100);
    cyc(); rst = 1'b1; #1;
    chk("mr_rst_mvalid", 32'(d_m_valid), 32'd0);
    chk("mr_rst_occ",    32'(d_occ),     32'd0);
    chk("mr_rst_sready", 32'(d_s_ready), 32'd0);
    cyc(); #1;
    chk("mr_rst_sready2", 32'(d_s_ready), 32'd0);
    rst = 1'b0; #1;
    chk("mr_rel_sready_pre", 32'(d_s_ready), 32'd0);
    cyc(); #1;
    chk("mr_rel_sready_post", 32'(d_s_ready), 32'd1);
    chk("mr_rel_mvalid",      32'(d_m_valid), 32'd0);
    chk("mr_rel_occ",         32'(d_occ),     32'd0);

    // ---------------- random backpressure: c, d scoreboarded; e bypass ----------------
    c_stall = 1'b0; d_stall = 1'b0; c_hold = 16'h0000; d_hold = 16'h0000; n = 0;
    for (int i = 0; i < 3040; i++) begin
      cyc();
      s_valid = (i < 3000) ? 1'($urandom_range(0, 1)) : 1'b0;
      m_ready = (i < 3000) ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = 16'(n);
      n++;
      #1;
      chk("byp_mdata",  32'(e_m_data),  32'(s_data));
      chk("byp_mvalid", 32'(e_m_valid), 32'(s_valid));
      chk("byp_sready", 32'(e_s_ready), 32'(m_ready));
      chk("byp_occ",    32'(e_occ),     32'd0);

      chk("rnd_c_occ", 32'(c_occ), 32'(qc.size()));
      if (c_stall) begin
        chk("rnd_c_stall_valid", 32'(c_m_valid), 32'd1);
        chk("rnd_c_stall_data",  32'(c_m_data),  32'(c_hold));
      end
      if (c_m_valid) begin
        if (qc.size() != 0) chk("rnd_c_data", 32'(c_m_data), 32'(qc[0]));
        else chk("rnd_c_spurious", 32'(c_m_valid), 32'd0);
        if (m_ready && qc.size() != 0) void'(qc.pop_front());
      end
      if (s_valid && c_s_ready) qc.push_back(s_data);
      c_stall = c_m_valid & ~m_ready;
      c_hold  = c_m_data;

      chk("rnd_d_occ", 32'(d_occ), 32'(qd.size()));
      if (d_stall) begin
        chk("rnd_d_stall_valid", 32'(d_m_valid), 32'd1);
        chk("rnd_d_stall_data",  32'(d_m_data),  32'(d_hold));
      end
      if (d_m_valid) begin
        if (qd.size() != 0) chk("rnd_d_data", 32'(d_m_data), 32'(qd[0]));
        else chk("rnd_d_spurious", 32'(d_m_valid), 32'd0);
        if (m_ready && qd.size() != 0) void'(qd.pop_front());
      end
      if (s_valid && d_s_ready) qd.push_back(s_data);
      d_stall = d_m_valid & ~m_ready;
      d_hold  = d_m_data;
    end
    cyc(); #1;
    chk("rnd_c_drained", 32'(c_occ), 32'd0);
    chk("rnd_d_drained", 32'(d_occ), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 128, payload width in bits.
REQ-002 SHALL provide parameter REG_TYPE, default 2, stage type: 0 = bypass wire, 1 = forward register, 2 = skid buffer.
REQ-003 SHALL provide parameter REG_LENGTH, default 1, number of cascaded stages, legal range 1..8.
REQ-004 SHALL derive local parameter OCC_WIDTH = $clog2(2*REG_LENGTH+1).
REQ-005 SHALL provide port clk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL provide port flush, input, 1, synchronous discard of all held words.
REQ-008 SHALL provide ports s_data / s_valid / s_ready, input / input / output, DATA_WIDTH / 1 / 1, upstream valid-ready channel.
REQ-009 SHALL provide ports m_data / m_valid / m_ready, output / output / input, DATA_WIDTH / 1 / 1, downstream valid-ready channel.
REQ-010 SHALL provide port occupancy, output, OCC_WIDTH, count of words currently held.

Function
REQ-011 SHALL transfer a word on any edge where valid and ready are both high; per-port ordering SHALL be strictly FIFO with no duplication or loss except by flush.
REQ-012 SHALL, for REG_TYPE 0, drive m_data = s_data, m_valid = s_valid and s_ready = m_ready combinationally; occupancy SHALL be 0; flush SHALL be ignored.
REQ-013 SHALL, for REG_TYPE 1, give each stage one data register plus valid bit, with stage ready = downstream ready OR NOT valid; latency = REG_LENGTH cycles; capacity = REG_LENGTH words.
REQ-014 SHALL, for REG_TYPE 2, give each stage a main register and a skid register, with s_ready driven only from a flop; latency = REG_LENGTH cycles; capacity = 2*REG_LENGTH words.
REQ-015 SHALL implement each type-2 stage as a 3-state FSM: EMPTY (ready=1, m_valid=0), ONE (ready=1, m_valid=1), FULL (ready=0, m_valid=1, skid occupied).
REQ-016 SHALL apply type-2 transitions as follows:
- EMPTY -> ONE on accept.
- ONE -> FULL on accept without drain.
- ONE -> EMPTY on drain without accept.
- ONE stays ONE on simultaneous accept and drain.
- FULL -> ONE on drain, with the skid word moving to the main register.
REQ-017 SHALL keep m_data stable while m_valid is high and m_ready is low, in all registered types.
REQ-018 SHALL, on flush high at an edge, clear every valid bit and skid state to EMPTY, discarding held words; occupancy SHALL read 0 the next cycle.
REQ-019 SHALL force s_ready low in any cycle flush is high (types 1, 2), so no word is accepted on a flush edge; m_valid SHALL be unaffected until that edge.
REQ-020 SHALL update occupancy registered each edge as held + accepted - delivered, saturating never needed by construction; occupancy SHALL never exceed capacity.
REQ-021 SHALL sustain one word per cycle throughput when m_ready is continuously high, in all types.
REQ-022 SHALL NOT reset data registers; only valid, FSM state, s_ready flop and occupancy are reset.

Reset
REQ-023 SHALL, while rst is high, force m_valid = 0, occupancy = 0, all stages EMPTY, and s_ready = 0 for types 1 and 2.
REQ-024 SHALL assert s_ready = 1 on the first edge after rst deasserts (types 1, 2); a word in flight when rst asserts SHALL be lost.
REQ-025 SHALL keep flush at lower priority than rst.

Verification
REQ-026 SHALL check stream: type 2, length 2, m_ready=1, s_valid=1 with data 0..99 -> m_data 0..99 in order, first word 2 cycles after the first accept, no bubbles.
REQ-027 SHALL check backpressure: type 2, length 1, m_ready=0, 3 words offered -> 2 accepted, s_ready low on third, occupancy=2; m_ready=1 -> words delivered in order, occupancy 2->1->0.
REQ-028 SHALL check flush: type 1, length 3, 3 words held, flush pulse with s_valid=1 -> that word not accepted, m_valid=0 and occupancy=0 next cycle, later words delivered correctly.
REQ-029 SHALL check reset mid-stream: type 2, length 4, occupancy=5, rst pulse -> m_valid=0, occupancy=0, s_ready=0 during reset, 1 one edge after release.
REQ-030 SHALL check bypass: type 0, random m_ready/s_valid -> m_* equals s_* every cycle, s_ready equals m_ready, occupancy=0.
REQ-031 SHALL check random backpressure: type 1 and type 2, length 1..8, 10k random cycles -> scoreboard exact match, m_data stable while stalled, occupancy equals the scoreboard depth every cycle.
